mm_bus_arbiter: RTL and testbench
=================================

// Module: mm_bus_arbiter
// PURPOSE
//  Shares one memory-mapped peripheral port (the GPIO/peripheral slave side) between two masters:
//  M0 = CPU load/store unit, M1 = debug/DMA master. Round-robin grant, one transaction in flight,
//  registered bus drive, completion handshake back to the granted master. Sits between the core
//  and the peripheral address decoder.
// PARAMETERS
//  ADDR_W          32  address width, both masters and peripheral bus
//  DATA_W          32  data width
//  TIMEOUT_CYCLES  16  ACCESS cycles before abort (used only with MM_ARB_TIMEOUT_EN); must be >= 1
// PORTS
//  CoreClock     in   1       clock; all logic on posedge
//  Reset         in   1       synchronous, active-high
//  M0_Req/M1_Req in   1       request; held high until Done seen
//  Mx_WriteEn    in   1       1 = write, 0 = read (x = 0,1)
//  Mx_Address    in   ADDR_W  transaction address
//  Mx_WriteData  in   DATA_W  write data
//  Mx_Done       out  1       one-cycle completion pulse to master x
//  Mx_Error      out  1       valid with Mx_Done; 1 = timed out
//  RdData        out  DATA_W  captured read data, shared; valid while any Mx_Done is high
//  AddressBus    out  ADDR_W  to peripheral
//  DataWriteBus  out  DATA_W  to peripheral
//  WriteAssert   out  1       peripheral write strobe
//  ReadAssert    out  1       peripheral read strobe
//  DataReadBus   in   DATA_W  from peripheral
//  ReadOK        in   1       peripheral read complete
//  WriteOK       in   1       peripheral write complete
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; RR pointer = M0 has priority; timeout counter 0.
//  FSM IDLE -> ACCESS -> COMPLETE -> IDLE.
//  IDLE: if any Req: grant by RR. Pointer favours the master not granted last.
//   Both Req -> favoured master wins. Single Req -> that master wins regardless of pointer.
//   Latch winner's Address/WriteData/WriteEn into the bus regs. Update pointer to the other master.
//   Go ACCESS. No Req -> stay IDLE with strobes 0.
//  ACCESS: AddressBus/DataWriteBus held from the latch.
//   WriteAssert = latched WriteEn; ReadAssert = ~latched WriteEn (registered, exactly one high).
//   Completion = (write & WriteOK) | (read & ReadOK), sampled each ACCESS cycle.
//   On completion: capture DataReadBus into RdData (reads only; writes leave RdData = 0).
//   Drop strobes. Go COMPLETE.
//  COMPLETE: granted Mx_Done = 1 (Mx_Error per timeout) for exactly this cycle. Req ignored.
//   Next state IDLE. Master must drop Req in the following cycle or it is a new request.
//  Latency: Req seen at cycle N -> strobe high N+1 -> with OK at N+1, Done at N+2.
//   Zero-wait throughput is 1 transaction per 3 cycles.
//  Req deasserted during ACCESS: ignored; transaction completes and Done still pulses.
//  Input changes after grant have no effect; bus values come from the latch only.
//  Wrong-direction OK (e.g. ReadOK during a write) is not completion.
//  AddressBus/DataWriteBus keep their last value outside ACCESS; only the strobes return to 0.
//  Reset in any state: abandon the transaction, no Done, all outputs to reset values next cycle.
// CONFIGURATION
//  MM_ARB_TIMEOUT_EN defined:
//   Counter clears on ACCESS entry and increments each ACCESS cycle without completion.
//   When it reaches TIMEOUT_CYCLES: drop strobes, RdData = 0, go COMPLETE with Mx_Error = 1.
//   Completion in the same cycle as expiry wins (Error = 0).
//  MM_ARB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; Mx_Error tied 0.
// TESTING
//  1 M0 read 0x000C, ReadOK=1, DataReadBus=0x3A5 -> ReadAssert at N+1, M0_Done + RdData=0x3A5 at N+2.
//  2 M1 write 0x0008 data 0xBEEF -> WriteAssert 1 cycle with DataWriteBus=0xBEEF, M1_Done, Error=0.
//  3 M0,M1 both Req continuously after reset -> grants M0,M1,M0,M1; Done every 3rd cycle.
//  4 Hold ReadOK=0 for 5 cycles, then 1 -> ReadAssert high 6 cycles; single Done; no extra transaction.
//  5 TIMEOUT_EN, TIMEOUT_CYCLES=4, OKs stuck 0 -> strobe drops after 4 cycles; Done, Error=1, RdData=0.
//  6 Reset pulsed mid-ACCESS -> strobes 0 next cycle; no Done; next grant goes to M0.

Source files
------------

// File: rtl/mm_bus_arbiter_if.sv
// rtl/mm_bus_arbiter_if.sv - bus bundle between two masters, the arbiter and one peripheral port
//
// Purpose: groups every handshake and bus signal of the arbiter into one bundle.
//   master modport : the system side (CPU LSU as M0, debug/DMA as M1, and the
//                    peripheral decoder) as seen from outside the arbiter
//   slave modport  : the arbiter's own view of the same wires
// Signals:
//   Mx_Req, Mx_WriteEn, Mx_Address, Mx_WriteData   master -> arbiter request
//   Mx_Done, Mx_Error                              arbiter -> master completion
//   RdData                                         captured read data (shared)
//   AddressBus, DataWriteBus, WriteAssert, ReadAssert  arbiter -> peripheral
//   DataReadBus, ReadOK, WriteOK                   peripheral -> arbiter
interface mm_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              M0_Req;
  logic              M0_WriteEn;
  logic [ADDR_W-1:0] M0_Address;
  logic [DATA_W-1:0] M0_WriteData;
  logic              M0_Done;
  logic              M0_Error;
  logic              M1_Req;
  logic              M1_WriteEn;
  logic [ADDR_W-1:0] M1_Address;
  logic [DATA_W-1:0] M1_WriteData;
  logic              M1_Done;
  logic              M1_Error;
  logic [DATA_W-1:0] RdData;
  logic [ADDR_W-1:0] AddressBus;
  logic [DATA_W-1:0] DataWriteBus;
  logic              WriteAssert;
  logic              ReadAssert;
  logic [DATA_W-1:0] DataReadBus;
  logic              ReadOK;
  logic              WriteOK;

  modport master (
    output M0_Req, M0_WriteEn, M0_Address, M0_WriteData,
    output M1_Req, M1_WriteEn, M1_Address, M1_WriteData,
    input  M0_Done, M0_Error, M1_Done, M1_Error, RdData,
    input  AddressBus, DataWriteBus, WriteAssert, ReadAssert,
    output DataReadBus, ReadOK, WriteOK
  );

  modport slave (
    input  M0_Req, M0_WriteEn, M0_Address, M0_WriteData,
    input  M1_Req, M1_WriteEn, M1_Address, M1_WriteData,
    output M0_Done, M0_Error, M1_Done, M1_Error, RdData,
    output AddressBus, DataWriteBus, WriteAssert, ReadAssert,
    input  DataReadBus, ReadOK, WriteOK
  );
endinterface

// File: rtl/mm_bus_arbiter.sv
// rtl/mm_bus_arbiter.sv - two-master round-robin arbiter onto one memory-mapped peripheral port
//
// Purpose: shares the peripheral port between M0 (CPU load/store) and M1 (debug/DMA).
//   Round-robin grant, one transaction in flight, registered bus drive, one-cycle
//   Done pulse back to the granted master. FSM: IDLE -> ACCESS -> COMPLETE -> IDLE.
// Ports:
//   CoreClock  clock, all logic on posedge
//   Reset      synchronous, active-high
//   bus        mm_bus_arbiter_if.slave (master requests, completion, peripheral bus)
// Optional feature macro: MM_ARB_TIMEOUT_EN
//   defined   : ACCESS aborts after TIMEOUT_CYCLES cycles without completion,
//               returning Done with Error = 1 and RdData = 0
//   undefined : ACCESS waits indefinitely, Error outputs tied 0
module mm_bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic            CoreClock,
  input logic            Reset,
  mm_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              gnt_q, gnt_d;     // granted master: 0 = M0, 1 = M1
  logic              rr_q, rr_d;       // favoured master on a tie: 0 = M0, 1 = M1
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wa_q, wa_d;
  logic              ra_q, ra_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic              hit;              // direction-matched completion this ACCESS cycle

`ifdef MM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]  tcnt_q, tcnt_d;
  logic              err_q, err_d;
`else
  logic              timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES >= 1);
`endif

  // Wrong-direction OK must not complete the transaction.
  assign hit = (we_q & bus.WriteOK) | (~we_q & bus.ReadOK);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wa_d    = 1'b0;
    ra_d    = 1'b0;
    rd_d    = rd_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
`ifdef MM_ARB_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.M0_Req || bus.M1_Req) begin
          // A lone requester wins outright; on a tie the pointer decides.
          gnt_d   = (bus.M0_Req && bus.M1_Req) ? rr_q : bus.M1_Req;
          rr_d    = ~gnt_d;
          we_d    = gnt_d ? bus.M1_WriteEn   : bus.M0_WriteEn;
          addr_d  = gnt_d ? bus.M1_Address   : bus.M0_Address;
          wdata_d = gnt_d ? bus.M1_WriteData : bus.M0_WriteData;
          wa_d    = we_d;
          ra_d    = ~we_d;
`ifdef MM_ARB_TIMEOUT_EN
          tcnt_d  = '0;
`endif
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        wa_d = wa_q;
        ra_d = ra_q;
        if (hit) begin
          // Completion beats a simultaneous timeout.
          wa_d    = 1'b0;
          ra_d    = 1'b0;
          rd_d    = we_q ? '0 : bus.DataReadBus;
          done0_d = ~gnt_q;
          done1_d = gnt_q;
          state_d = COMPLETE;
        end
`ifdef MM_ARB_TIMEOUT_EN
        else if (tcnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          wa_d    = 1'b0;
          ra_d    = 1'b0;
          rd_d    = '0;
          done0_d = ~gnt_q;
          done1_d = gnt_q;
          err_d   = 1'b1;
          state_d = COMPLETE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
`endif
      end
      COMPLETE: begin
        // Requests are ignored here; a Req still high next cycle is a new request.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CoreClock) begin
    if (Reset) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      rr_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wa_q    <= 1'b0;
      ra_q    <= 1'b0;
      rd_q    <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
`ifdef MM_ARB_TIMEOUT_EN
      tcnt_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wa_q    <= wa_d;
      ra_q    <= ra_d;
      rd_q    <= rd_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
`ifdef MM_ARB_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.AddressBus   = addr_q;
  assign bus.DataWriteBus = wdata_q;
  assign bus.WriteAssert  = wa_q;
  assign bus.ReadAssert   = ra_q;
  assign bus.RdData       = rd_q;
  assign bus.M0_Done      = done0_q;
  assign bus.M1_Done      = done1_q;
`ifdef MM_ARB_TIMEOUT_EN
  assign bus.M0_Error     = done0_q & err_q;
  assign bus.M1_Error     = done1_q & err_q;
`else
  assign bus.M0_Error     = 1'b0;
  assign bus.M1_Error     = 1'b0;
`endif

endmodule

// File: tb/tb_mm_bus_arbiter.sv
// tb/tb_mm_bus_arbiter.sv - directed self-checking bench for mm_bus_arbiter
module tb_mm_bus_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
`ifdef MM_ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic CoreClock = 1'b0;
  logic Reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  mm_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mm_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
    .CoreClock (CoreClock),
    .Reset     (Reset),
    .bus       (bus)
  );

  always #5 CoreClock = ~CoreClock;

  task automatic tick;
    @(posedge CoreClock);
    #1;
  endtask

  task automatic idle_inputs;
    bus.M0_Req = 0; bus.M0_WriteEn = 0; bus.M0_Address = '0; bus.M0_WriteData = '0;
    bus.M1_Req = 0; bus.M1_WriteEn = 0; bus.M1_Address = '0; bus.M1_WriteData = '0;
    bus.DataReadBus = '0; bus.ReadOK = 0; bus.WriteOK = 0;
  endtask

  task automatic do_reset;
    idle_inputs();
    Reset = 1;
    tick();
    tick();
    Reset = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    bus.M0_Req = 1; bus.M1_Req = 1; bus.ReadOK = 1; bus.WriteOK = 1;
    bus.M0_Address = 32'hFFFF; bus.DataReadBus = 32'h1234;
    Reset = 1;
    tick();
    tick();
    n_checks++;
    if ({bus.WriteAssert, bus.ReadAssert, bus.M0_Done, bus.M1_Done, bus.M0_Error, bus.M1_Error} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b exp 000000", {bus.WriteAssert, bus.ReadAssert, bus.M0_Done, bus.M1_Done, bus.M0_Error, bus.M1_Error});
    end
    n_checks++;
    if ({bus.AddressBus, bus.DataWriteBus, bus.RdData} !== '0) begin
      n_fail++;
      $display("FAIL reset_data got %h %h %h exp 0", bus.AddressBus, bus.DataWriteBus, bus.RdData);
    end
    idle_inputs();
    tick();
    Reset = 0;
  endtask

  task automatic test_read;
    bus.M0_Req = 1; bus.M0_WriteEn = 0; bus.M0_Address = 32'h000C;
    bus.ReadOK = 1; bus.DataReadBus = 32'h3A5;
    tick();
    n_checks++;
    if ({bus.WriteAssert, bus.ReadAssert, bus.M0_Done, bus.M1_Done} !== 4'b0100 || bus.AddressBus !== 32'h000C) begin
      n_fail++;
      $display("FAIL read_strobe got %b addr %h exp 0100 addr 0000000c", {bus.WriteAssert, bus.ReadAssert, bus.M0_Done, bus.M1_Done}, bus.AddressBus);
    end
    tick();
    n_checks++;
    if ({bus.WriteAssert, bus.ReadAssert, bus.M0_Done, bus.M1_Done, bus.M0_Error} !== 5'b00100) begin
      n_fail++;
      $display("FAIL read_done got %b exp 00100", {bus.WriteAssert, bus.ReadAssert, bus.M0_Done, bus.M1_Done, bus.M0_Error});
    end
    n_checks++;
    if (bus.RdData !== 32'h3A5) begin
      n_fail++;
      $display("FAIL read_data got %h exp 000003a5", bus.RdData);
    end
    idle_inputs();
    tick();
    n_checks++;
    if ({bus.M0_Done, bus.M1_Done, bus.ReadAssert} !== 3'b0) begin
      n_fail++;
      $display("FAIL read_after got %b exp 000", {bus.M0_Done, bus.M1_Done, bus.ReadAssert});
    end
  endtask

  task automatic test_write;
    bus.M1_Req = 1; bus.M1_WriteEn = 1; bus.M1_Address = 32'h0008; bus.M1_WriteData = 32'hBEEF;
    bus.WriteOK = 1;
    tick();
    n_checks++;
    if ({bus.WriteAssert, bus.ReadAssert} !== 2'b10 || bus.DataWriteBus !== 32'hBEEF || bus.AddressBus !== 32'h8) begin
      n_fail++;
      $display("FAIL write_strobe got %b data %h addr %h exp 10 data beef addr 8", {bus.WriteAssert, bus.ReadAssert}, bus.DataWriteBus, bus.AddressBus);
    end
    tick();
    n_checks++;
    if ({bus.WriteAssert, bus.ReadAssert, bus.M0_Done, bus.M1_Done, bus.M1_Error} !== 5'b00010 || bus.RdData !== '0) begin
      n_fail++;
      $display("FAIL write_done got %b rd %h exp 00010 rd 0", {bus.WriteAssert, bus.ReadAssert, bus.M0_Done, bus.M1_Done, bus.M1_Error}, bus.RdData);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_wrong_ok_and_latch;
    bus.M1_Req = 1; bus.M1_WriteEn = 1; bus.M1_Address = 32'h10; bus.M1_WriteData = 32'h1234;
    bus.ReadOK = 1; bus.WriteOK = 0;
    tick();
    bus.M1_Address = 32'hFFF0; bus.M1_WriteData = 32'hDEAD; bus.M1_Req = 0; bus.M1_WriteEn = 0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if ({bus.WriteAssert, bus.ReadAssert, bus.M0_Done, bus.M1_Done} !== 4'b1000 ||
          bus.AddressBus !== 32'h10 || bus.DataWriteBus !== 32'h1234) begin
        n_fail++;
        $display("FAIL latch_hold got %b addr %h data %h exp 1000 addr 10 data 1234", {bus.WriteAssert, bus.ReadAssert, bus.M0_Done, bus.M1_Done}, bus.AddressBus, bus.DataWriteBus);
      end
    end
    bus.WriteOK = 1;
    tick();
    n_checks++;
    if ({bus.WriteAssert, bus.M0_Done, bus.M1_Done} !== 3'b001) begin
      n_fail++;
      $display("FAIL dropped_req_done got %b exp 001", {bus.WriteAssert, bus.M0_Done, bus.M1_Done});
    end
    tick();
    tick();
    n_checks++;
    if ({bus.WriteAssert, bus.ReadAssert, bus.M0_Done, bus.M1_Done} !== 4'b0 || bus.AddressBus !== 32'h10) begin
      n_fail++;
      $display("FAIL idle_keep_bus got %b addr %h exp 0000 addr 10", {bus.WriteAssert, bus.ReadAssert, bus.M0_Done, bus.M1_Done}, bus.AddressBus);
    end
    idle_inputs();
  endtask

  task automatic test_round_robin;
    logic [3:0]  exp_ctl;
    logic [31:0] exp_addr;
    do_reset();
    bus.M0_Req = 1; bus.M0_WriteEn = 0; bus.M0_Address = 32'h100;
    bus.M1_Req = 1; bus.M1_WriteEn = 1; bus.M1_Address = 32'h200; bus.M1_WriteData = 32'h55;
    bus.ReadOK = 1; bus.WriteOK = 1; bus.DataReadBus = 32'h77;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_addr = ((i / 3) % 2 == 1) ? 32'h200 : 32'h100;
      case (i % 3)
        0:       exp_ctl = ((i / 3) % 2 == 1) ? 4'b1000 : 4'b0100;
        1:       exp_ctl = ((i / 3) % 2 == 1) ? 4'b0001 : 4'b0010;
        default: exp_ctl = 4'b0000;
      endcase
      n_checks++;
      if ({bus.WriteAssert, bus.ReadAssert, bus.M0_Done, bus.M1_Done} !== exp_ctl || bus.AddressBus !== exp_addr) begin
        n_fail++;
        $display("FAIL rr_cycle%0d got %b addr %h exp %b addr %h", i, {bus.WriteAssert, bus.ReadAssert, bus.M0_Done, bus.M1_Done}, bus.AddressBus, exp_ctl, exp_addr);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_wait_states;
    int ra_cnt, done_cnt, done_at;
    logic [31:0] rd_at_done;
    ra_cnt = 0; done_cnt = 0; done_at = -1; rd_at_done = '0;
    do_reset();
    bus.M0_Req = 1; bus.M0_WriteEn = 0; bus.M0_Address = 32'h20;
    bus.ReadOK = 0; bus.DataReadBus = 32'h1AB;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (bus.ReadAssert) ra_cnt++;
      if (bus.M0_Done || bus.M1_Done) begin
        done_cnt++;
        done_at = c;
        rd_at_done = bus.RdData;
        bus.M0_Req = 0;
      end
      if (c == 6) bus.ReadOK = 1;
    end
    n_checks++;
    if (ra_cnt != 6) begin
      n_fail++;
      $display("FAIL wait_ra_cycles got %0d exp 6", ra_cnt);
    end
    n_checks++;
    if (done_cnt != 1 || done_at != 7) begin
      n_fail++;
      $display("FAIL wait_done got count %0d at %0d exp count 1 at 7", done_cnt, done_at);
    end
    n_checks++;
    if (rd_at_done !== 32'h1AB) begin
      n_fail++;
      $display("FAIL wait_rddata got %h exp 000001ab", rd_at_done);
    end
    idle_inputs();
  endtask

`ifdef MM_ARB_TIMEOUT_EN
  task automatic test_timeout;
    int ra_cnt, done_at;
    logic err_at_done;
    logic [31:0] rd_at_done;
    ra_cnt = 0; done_at = -1; err_at_done = 0; rd_at_done = 32'hFFFF_FFFF;
    do_reset();
    bus.M1_Req = 1; bus.M1_WriteEn = 0; bus.M1_Address = 32'h44; bus.DataReadBus = 32'h999;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (bus.ReadAssert) ra_cnt++;
      if (bus.M1_Done) begin
        done_at = c;
        err_at_done = bus.M1_Error;
        rd_at_done = bus.RdData;
        bus.M1_Req = 0;
      end
    end
    n_checks++;
    if (ra_cnt != 4 || done_at != 5) begin
      n_fail++;
      $display("FAIL timeout_timing got ra %0d done_at %0d exp ra 4 done_at 5", ra_cnt, done_at);
    end
    n_checks++;
    if (err_at_done !== 1'b1 || rd_at_done !== '0) begin
      n_fail++;
      $display("FAIL timeout_err got err %b rd %h exp err 1 rd 0", err_at_done, rd_at_done);
    end
    idle_inputs();
  endtask
`endif

  task automatic test_reset_mid_access;
    do_reset();
    bus.M0_Req = 1; bus.M0_WriteEn = 0; bus.M0_Address = 32'h30; bus.ReadOK = 0;
    tick();
    n_checks++;
    if (bus.ReadAssert !== 1'b1 || bus.AddressBus !== 32'h30) begin
      n_fail++;
      $display("FAIL mid_pre got ra %b addr %h exp ra 1 addr 30", bus.ReadAssert, bus.AddressBus);
    end
    Reset = 1;
    tick();
    n_checks++;
    if ({bus.WriteAssert, bus.ReadAssert, bus.M0_Done, bus.M1_Done} !== 4'b0 || bus.AddressBus !== '0) begin
      n_fail++;
      $display("FAIL mid_reset got %b addr %h exp 0000 addr 0", {bus.WriteAssert, bus.ReadAssert, bus.M0_Done, bus.M1_Done}, bus.AddressBus);
    end
    Reset = 0;
    bus.M1_Req = 1; bus.M1_WriteEn = 1; bus.M1_Address = 32'h40;
    tick();
    n_checks++;
    if ({bus.WriteAssert, bus.ReadAssert, bus.M0_Done, bus.M1_Done} !== 4'b0100 || bus.AddressBus !== 32'h30) begin
      n_fail++;
      $display("FAIL mid_regrant got %b addr %h exp 0100 addr 30", {bus.WriteAssert, bus.ReadAssert, bus.M0_Done, bus.M1_Done}, bus.AddressBus);
    end
    bus.ReadOK = 1;
    tick();
    n_checks++;
    if ({bus.M0_Done, bus.M1_Done} !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_done got %b exp 10", {bus.M0_Done, bus.M1_Done});
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    Reset = 1;
    idle_inputs();
    test_reset();
    test_read();
    test_write();
    test_wrong_ok_and_latch();
    test_round_robin();
    test_wait_states();
`ifdef MM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
